// File: rtl/avalon_add_driver.sv
// avalon_add_driver: Avalon-MM master that checks the adder ID, writes A/B, reads the sum back
// and compares it against a locally computed 33-bit reference.
module avalon_add_driver #(
   parameter logic [31:0] ID_VALUE = 32'h12345678,
   parameter bit          CHECK_ID = 1'b1,
   parameter int          CNT_W    = 16
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             start,
   input  logic [31:0]      op_a,
   input  logic [31:0]      op_b,
   output logic             busy,
   output logic             done,
   output logic [31:0]      sum,
   output logic             carry,
   output logic             mismatch,
   output logic             id_err,
   output logic [CNT_W-1:0] err_count,
   output logic [2:0]       m_address,
   output logic             m_write,
   output logic [31:0]      m_writedata,
   output logic             m_read,
   input  logic [31:0]      m_readdata
);
   typedef enum logic [2:0] {IDLE, ID_RD, ID_WAIT, WR_A, WR_B, SUM_RD, SUM_WAIT, DONE} state_t;
   state_t            state_q;
   logic [31:0]       a_q, b_q, exp_q, sum_q, m_writedata_q;
   logic              carry_n_q, carry_q, mismatch_q, id_err_q, id_ok_q, busy_q, done_q;
   logic              m_read_q, m_write_q;
   logic [2:0]        m_address_q;
   logic [CNT_W-1:0]  err_count_q, err_count_d;
   assign err_count_d = &err_count_q ? err_count_q : err_count_q + 1'b1;
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q       <= IDLE;
         a_q           <= '0;
         b_q           <= '0;
         exp_q         <= '0;
         carry_n_q     <= 1'b0;
         sum_q         <= '0;
         carry_q       <= 1'b0;
         mismatch_q    <= 1'b0;
         id_err_q      <= 1'b0;
         id_ok_q       <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         err_count_q   <= '0;
         m_read_q      <= 1'b0;
         m_write_q     <= 1'b0;
         m_address_q   <= '0;
         m_writedata_q <= '0;
      end else begin
         m_read_q      <= 1'b0;
         m_write_q     <= 1'b0;
         m_address_q   <= '0;
         m_writedata_q <= '0;
         done_q        <= 1'b0;
         case (state_q)
            IDLE: if (start) begin
               a_q                <= op_a;
               b_q                <= op_b;
               {carry_n_q, exp_q} <= {1'b0, op_a} + {1'b0, op_b};
               busy_q             <= 1'b1;
               if (CHECK_ID && !id_ok_q) begin
                  state_q     <= ID_RD;
                  m_read_q    <= 1'b1;
                  m_address_q <= 3'd3;
               end else begin
                  state_q       <= WR_A;
                  m_write_q     <= 1'b1;
                  m_writedata_q <= op_a;
               end
            end
            ID_RD: state_q <= ID_WAIT;
            ID_WAIT: if (m_readdata == ID_VALUE) begin
               id_ok_q       <= 1'b1;
               state_q       <= WR_A;
               m_write_q     <= 1'b1;
               m_writedata_q <= a_q;
            end else begin
               // failed ID: report a mismatch without touching the slave
               id_err_q    <= 1'b1;
               sum_q       <= '0;
               carry_q     <= 1'b0;
               mismatch_q  <= 1'b1;
               err_count_q <= err_count_d;
               done_q      <= 1'b1;
               state_q     <= DONE;
            end
            WR_A: begin
               state_q       <= WR_B;
               m_write_q     <= 1'b1;
               m_address_q   <= 3'd1;
               m_writedata_q <= b_q;
            end
            WR_B: begin
               state_q     <= SUM_RD;
               m_read_q    <= 1'b1;
               m_address_q <= 3'd2;
            end
            SUM_RD: state_q <= SUM_WAIT;
            SUM_WAIT: begin
               sum_q      <= m_readdata;
               carry_q    <= carry_n_q;
               mismatch_q <= m_readdata != exp_q;
               if (m_readdata != exp_q) err_count_q <= err_count_d;
               done_q     <= 1'b1;
               state_q    <= DONE;
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   // strobes are gated so they fall in the very cycle reset is asserted
   assign m_read      = m_read_q & resetn;
   assign m_write     = m_write_q & resetn;
   assign m_address   = m_address_q;
   assign m_writedata = m_writedata_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign sum         = sum_q;
   assign carry       = carry_q;
   assign mismatch    = mismatch_q;
   assign id_err      = id_err_q;
   assign err_count   = err_count_q;
endmodule

// File: tb/tb_avalon_add_driver.sv
// tb_avalon_add_driver: drives operations against a behavioural adder slave and checks
// results, latency and bus sequence against a transaction-level reference model.
module tb_avalon_add_driver;
   localparam int          CNT_W = 4;
   localparam logic [31:0] ID    = 32'h12345678;
   localparam int          MAXC  = 2**CNT_W - 1;
   logic clock = 0, resetn = 0, start = 0;
   logic [31:0] op_a = 0, op_b = 0, m_readdata = 0;
   logic busy, done, carry, mismatch, id_err, m_write, m_read;
   logic [31:0] sum, m_writedata;
   logic [CNT_W-1:0] err_count;
   logic [2:0] m_address;
   int checks = 0, errors = 0;
   logic [31:0] s_a = 0, s_b = 0, s_sum;
   bit id_bad = 0, stuck = 0;
   bit mid_ok = 0, mid_err = 0;
   int merr = 0;
   logic [35:0] log_q[$];

   always #5 clock = ~clock;

   avalon_add_driver #(.ID_VALUE(ID), .CHECK_ID(1'b1), .CNT_W(CNT_W)) dut (
      .clock(clock), .resetn(resetn), .start(start), .op_a(op_a), .op_b(op_b),
      .busy(busy), .done(done), .sum(sum), .carry(carry), .mismatch(mismatch),
      .id_err(id_err), .err_count(err_count), .m_address(m_address), .m_write(m_write),
      .m_writedata(m_writedata), .m_read(m_read), .m_readdata(m_readdata));

   // adder slave: registered readdata, optional bad ID and stuck-at-0 sum bit 0
   assign s_sum = stuck ? ((s_a + s_b) & ~32'd1) : s_a + s_b;
   always @(posedge clock) begin
      if (m_write && m_address == 3'd0) s_a <= m_writedata;
      if (m_write && m_address == 3'd1) s_b <= m_writedata;
      if (m_read) m_readdata <= m_address == 3'd3 ? (id_bad ? 32'hDEADBEEF : ID) :
                                m_address == 3'd2 ? s_sum : m_address == 3'd1 ? s_b : s_a;
      if (m_write) log_q.push_back({1'b1, m_address, m_writedata});
      if (m_read) log_q.push_back({1'b0, m_address, 32'd0});
      if (m_read || m_write) begin
         checks++;
         if (m_read && m_write) begin
            errors++;
            $display("FAIL strobe_overlap: read=%b write=%b, required not both high", m_read, m_write);
         end
      end
   end

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int pulse_at);
      logic [32:0] full;
      logic [31:0] esum;
      logic [35:0] exp_q[$];
      bit need_id, fail, ec, em, ok;
      int n, lat;
      need_id = !mid_ok;
      fail = need_id && id_bad;
      full = {1'b0, a} + {1'b0, b};
      esum = fail ? 32'd0 : stuck ? (full[31:0] & ~32'd1) : full[31:0];
      ec = fail ? 1'b0 : full[32];
      em = fail || (stuck && full[0]);
      lat = need_id ? (fail ? 3 : 7) : 5;
      if (need_id) exp_q.push_back({1'b0, 3'd3, 32'd0});
      if (!fail) begin
         exp_q.push_back({1'b1, 3'd0, a});
         exp_q.push_back({1'b1, 3'd1, b});
         exp_q.push_back({1'b0, 3'd2, 32'd0});
      end
      if (em && merr < MAXC) merr++;
      if (need_id && !fail) mid_ok = 1;
      if (fail) mid_err = 1;
      @(negedge clock);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL busy_before_start: got %b want 0", busy); end
      start = 1; op_a = a; op_b = b;
      log_q.delete();
      @(posedge clock);
      n = 1;
      while (1) begin
         @(negedge clock);
         if (done === 1'b1 || n >= 20) break;
         start = (n == pulse_at);
         op_a = $urandom; op_b = $urandom;
         @(posedge clock);
         n++;
      end
      start = 0;
      checks++;
      if (n !== lat) begin errors++; $display("FAIL latency: got %0d want %0d", n, lat); end
      checks++;
      if (sum !== esum) begin errors++; $display("FAIL sum: got %h want %h", sum, esum); end
      checks++;
      if (carry !== ec) begin errors++; $display("FAIL carry: got %b want %b", carry, ec); end
      checks++;
      if (mismatch !== em) begin errors++; $display("FAIL mismatch: got %b want %b", mismatch, em); end
      checks++;
      if (id_err !== mid_err) begin errors++; $display("FAIL id_err: got %b want %b", id_err, mid_err); end
      checks++;
      if (err_count !== CNT_W'(merr)) begin errors++; $display("FAIL err_count: got %0d want %0d", err_count, merr); end
      ok = log_q.size() == exp_q.size();
      for (int i = 0; i < exp_q.size(); i++) if (ok && log_q[i] !== exp_q[i]) ok = 0;
      checks++;
      if (!ok) begin errors++; $display("FAIL bus_sequence: got %0d transactions want %0d (or contents differ)", log_q.size(), exp_q.size()); end
      @(posedge clock);
      @(negedge clock);
      checks++;
      if ({done, busy} !== 2'b00) begin errors++; $display("FAIL idle_after_done: done=%b busy=%b want 0 0", done, busy); end
   endtask

   task automatic test_reset;
      resetn = 0;
      repeat (3) @(negedge clock);
      checks++;
      if ({busy, done, sum, carry, mismatch, id_err, err_count, m_address, m_write, m_writedata, m_read} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: busy=%b done=%b sum=%h err_count=%0d m_read=%b m_write=%b want all 0",
                  busy, done, sum, err_count, m_read, m_write);
      end
      resetn = 1;
      @(negedge clock);
   endtask

   task automatic test_basic;
      run_op(32'd5, 32'd7, 0);
      run_op(32'hFFFFFFFF, 32'h00000002, 0);
   endtask

   task automatic test_random;
      repeat (10) begin
         stuck = bit'($urandom_range(0, 1));
         run_op($urandom, $urandom, 0);
      end
      stuck = 0;
   endtask

   task automatic test_start_while_busy;
      run_op($urandom, $urandom, 2);
   endtask

   task automatic test_back_to_back;
      logic [31:0] a, b;
      int n, d1, d2;
      a = $urandom; b = $urandom;
      n = 0; d1 = -1; d2 = -1;
      @(negedge clock);
      start = 1; op_a = a; op_b = b;
      while (n < 40 && d2 < 0) begin
         @(posedge clock);
         n++;
         @(negedge clock);
         if (done === 1'b1) begin
            if (d1 < 0) d1 = n;
            else d2 = n;
         end
      end
      start = 0;
      checks++;
      if (d1 !== 5) begin errors++; $display("FAIL b2b_first_done: got %0d want 5", d1); end
      checks++;
      if (d2 !== 11) begin errors++; $display("FAIL b2b_second_done: got %0d want 11", d2); end
      checks++;
      if (sum !== a + b) begin errors++; $display("FAIL b2b_sum: got %h want %h", sum, a + b); end
      @(posedge clock);
      @(negedge clock);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: busy=%b want 0", busy); end
   endtask

   task automatic test_reset_mid;
      bit saw_done;
      @(negedge clock);
      start = 1; op_a = $urandom; op_b = $urandom;
      @(posedge clock);
      @(negedge clock);
      start = 0;
      repeat (2) begin @(posedge clock); @(negedge clock); end
      checks++;
      if ({m_read, m_address} !== {1'b1, 3'd2}) begin errors++; $display("FAIL sum_rd_state: read=%b addr=%0d want 1 2", m_read, m_address); end
      resetn = 0;
      #1;
      checks++;
      if (m_read !== 1'b0) begin errors++; $display("FAIL read_drop: got %b want 0", m_read); end
      @(posedge clock);
      @(negedge clock);
      checks++;
      if ({busy, done, sum} !== '0) begin errors++; $display("FAIL reset_mid_outputs: busy=%b done=%b sum=%h want 0", busy, done, sum); end
      mid_ok = 0; mid_err = 0; merr = 0;
      resetn = 1;
      saw_done = 0;
      repeat (6) begin @(negedge clock); if (done !== 1'b0) saw_done = 1; end
      checks++;
      if (saw_done) begin errors++; $display("FAIL done_after_reset: got pulse want none"); end
   endtask

   task automatic test_id_fail;
      id_bad = 1;
      run_op($urandom, $urandom, 0);
      run_op($urandom, $urandom, 0);
      id_bad = 0;
      run_op($urandom, $urandom, 0);
   endtask

   task automatic test_saturation;
      stuck = 1;
      repeat (2**CNT_W + 1) run_op(32'd1, 32'd2, 0);
      checks++;
      if (err_count !== CNT_W'(MAXC)) begin errors++; $display("FAIL saturate: got %0d want %0d", err_count, MAXC); end
      stuck = 0;
   endtask

   initial begin
      test_reset;
      test_basic;
      test_random;
      test_start_while_busy;
      test_back_to_back;
      test_reset_mid;
      test_id_fail;
      test_saturation;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
